// File: rtl/multi_byte_adder_pkg.sv
// -----------------------------------------------------------------------------
// multi_byte_adder_pkg
// Shared constants and types for the multi-byte adder sequencer.
//   BYTE_WIDTH : width of one adder slice (the shared CLA adds one byte/cycle)
//   state_e    : sequencer FSM states
// -----------------------------------------------------------------------------
package multi_byte_adder_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for a request, Ready_Out high
        ADD  = 2'd1,  // one byte added per cycle, LSB first
        DONE = 2'd2   // result published, Done_Out pulses
    } state_e;

endpackage

// File: rtl/multi_byte_adder_sequencer_if.sv
// -----------------------------------------------------------------------------
// multi_byte_adder_sequencer_if
// Request/result bundle of the multi-byte adder sequencer.
//   master : requester side (drives Start_In, operands, Carry_In)
//   slave  : sequencer side (drives Ready_Out, Sum_Out, Carry_Out,
//            Overflow_Out, Done_Out)
// NUM_BYTES must match the sequencer it is connected to.
// -----------------------------------------------------------------------------
interface multi_byte_adder_sequencer_if
    import multi_byte_adder_pkg::*;
#(
    parameter int NUM_BYTES = 4
);
    localparam int W = NUM_BYTES * BYTE_WIDTH;

    logic         Start_In;
    logic         Ready_Out;
    logic [W-1:0] Data_A_In;
    logic [W-1:0] Data_B_In;
    logic         Carry_In;
    logic [W-1:0] Sum_Out;
    logic         Carry_Out;
    logic         Overflow_Out;
    logic         Done_Out;

    modport master (
        output Start_In, Data_A_In, Data_B_In, Carry_In,
        input  Ready_Out, Sum_Out, Carry_Out, Overflow_Out, Done_Out
    );

    modport slave (
        input  Start_In, Data_A_In, Data_B_In, Carry_In,
        output Ready_Out, Sum_Out, Carry_Out, Overflow_Out, Done_Out
    );

endinterface

// File: rtl/byte_cla_adder.sv
// -----------------------------------------------------------------------------
// byte_cla_adder
// Combinational 8-bit carry-lookahead adder.
//   Data_A_In, Data_B_In : byte operands
//   Carry_In             : carry into bit 0
//   Sum_Out              : A + B + Carry_In (low 8 bits)
//   Carry_Out            : carry out of bit 7
// -----------------------------------------------------------------------------
module byte_cla_adder
    import multi_byte_adder_pkg::*;
(
    input  logic [BYTE_WIDTH-1:0] Data_A_In,
    input  logic [BYTE_WIDTH-1:0] Data_B_In,
    input  logic                  Carry_In,
    output logic [BYTE_WIDTH-1:0] Sum_Out,
    output logic                  Carry_Out
);
    logic [BYTE_WIDTH-1:0] prop;
    logic [BYTE_WIDTH-1:0] gen;
    logic [BYTE_WIDTH:0]   carry;

    assign prop = Data_A_In ^ Data_B_In;
    assign gen  = Data_A_In & Data_B_In;

    // Each carry is the flat sum-of-products of generate/propagate terms
    // (c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin), not a ripple chain.
    always_comb begin
        logic acc;
        logic run_p;
        // NOTE: every variable assigned in always_comb gets a value on every
        // path first; otherwise synthesis infers a latch to hold the old one.
        carry    = '0;
        carry[0] = Carry_In;
        acc      = 1'b0;
        run_p    = 1'b0;
        for (int i = 0; i < BYTE_WIDTH; i++) begin
            acc   = gen[i];
            run_p = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc   = acc | (run_p & gen[j]);
                run_p = run_p & prop[j];
            end
            carry[i+1] = acc | (run_p & Carry_In);
        end
    end

    assign Sum_Out   = prop ^ carry[BYTE_WIDTH-1:0];
    assign Carry_Out = carry[BYTE_WIDTH];

endmodule

// File: rtl/multi_byte_adder_sequencer.sv
// -----------------------------------------------------------------------------
// multi_byte_adder_sequencer
// Adds two NUM_BYTES-wide operands plus a carry-in through one shared 8-bit
// CLA, one byte per cycle, LSB byte first.
//   Clock   : rising-edge clock
//   Reset_n : synchronous active-low reset (aborts any operation in flight)
//   bus     : slave side of multi_byte_adder_sequencer_if
// Timing: accept at edge k, Done_Out high in the cycle after edge k+NUM_BYTES,
// next accept possible at edge k+NUM_BYTES+2.
// -----------------------------------------------------------------------------
module multi_byte_adder_sequencer
    import multi_byte_adder_pkg::*;
#(
    parameter int NUM_BYTES = 4   // legal range 2..16
)(
    input  logic                         Clock,
    input  logic                         Reset_n,
    multi_byte_adder_sequencer_if.slave  bus
);
    localparam int                W        = NUM_BYTES * BYTE_WIDTH;
    localparam int                IDX_W    = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic [W-1:0]     work_q,  work_d;
    logic [W-1:0]     sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    logic                  ready;
    logic                  done;
    logic                  accept;
    logic [BYTE_WIDTH-1:0] byte_sum;
    logic                  byte_cout;

    assign accept = bus.Start_In && ready;

    // The single shared adder; the current byte is picked by the index.
    byte_cla_adder u_byte_cla_adder (
        .Data_A_In (a_q[int'(idx_q)*BYTE_WIDTH +: BYTE_WIDTH]),
        .Data_B_In (b_q[int'(idx_q)*BYTE_WIDTH +: BYTE_WIDTH]),
        .Carry_In  (carry_q),
        .Sum_Out   (byte_sum),
        .Carry_Out (byte_cout)
    );

    // State register
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!Reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ADD;
            ADD:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, byte accumulation, result publication
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.Data_A_In;
                    b_d     = bus.Data_B_In;
                    carry_d = bus.Carry_In;
                    idx_d   = '0;
                    work_d  = '0;
                end
            end
            ADD: begin
                work_d[int'(idx_q)*BYTE_WIDTH +: BYTE_WIDTH] = byte_sum;
                carry_d = byte_cout;
                if (idx_q == LAST_IDX) begin
                    // The MSB byte is still in flight, so publish work_d
                    // (which already contains it) rather than work_q.
                    sum_d  = work_d;
                    cout_d = byte_cout;
                    ovf_d  = (a_q[W-1] == b_q[W-1]) && (work_d[W-1] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state_q == IDLE) && Reset_n;
        done  = (state_q == DONE);
    end

    assign bus.Ready_Out    = ready;
    assign bus.Done_Out     = done;
    assign bus.Sum_Out      = sum_q;
    assign bus.Carry_Out    = cout_q;
    assign bus.Overflow_Out = ovf_q;

endmodule

// File: doc/multi_byte_adder_sequencer.md
MULTI_BYTE_ADDER_SEQUENCER -- requirements
Module: multi_byte_adder_sequencer

Interface
REQ-001 Parameter NUM_BYTES, default 4, operand width in bytes; legal range 2..16.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  reset, synchronous, active-low.
REQ-004 Start_In  input  1  request valid; operands and Carry_In qualified by it.
REQ-005 Ready_Out  output  1  sequencer can accept a request this cycle.
REQ-006 Data_A_In  input  8*NUM_BYTES  operand A, unsigned or two's complement.
REQ-007 Data_B_In  input  8*NUM_BYTES  operand B.
REQ-008 Carry_In  input  1  carry into byte 0.
REQ-009 Sum_Out  output  8*NUM_BYTES  registered result of last completed add.
REQ-010 Carry_Out  output  1  carry out of MSB byte, last completed add.
REQ-011 Overflow_Out  output  1  signed overflow, last completed add.
REQ-012 Done_Out  output  1  one-cycle pulse marking a new result on Sum_Out/Carry_Out/Overflow_Out.

Function
REQ-013 The block SHALL compute A+B+Carry_In using one shared 8-bit carry-lookahead adder, one byte per cycle, LSB byte first.
REQ-014 FSM states: IDLE, ADD, DONE; IDLE->ADD on accept; ADD->DONE after byte NUM_BYTES-1; DONE->IDLE unconditionally.
REQ-015 Ready_Out SHALL be 1 only in IDLE with Reset_n high; accept = Start_In && Ready_Out at a rising edge.
REQ-016 On accept, the block SHALL latch both operands and Carry_In into internal registers and clear the byte index to 0.
REQ-017 In ADD, byte index i (0..NUM_BYTES-1) SHALL add byte i of latched A and B with the carry register; the sum byte goes to a working result register; the adder carry-out goes back to the carry register.
REQ-018 The byte index SHALL increment each ADD cycle and SHALL NOT wrap; exit to DONE occurs on i==NUM_BYTES-1.
REQ-019 On the ADD->DONE edge, Sum_Out, Carry_Out and Overflow_Out SHALL load together; Done_Out SHALL be 1 for exactly the DONE cycle.
REQ-020 Latency: accept at edge k; Done_Out high in the cycle after edge k+NUM_BYTES; next accept possible at edge k+NUM_BYTES+2.
REQ-021 Overflow_Out = (A_msb == B_msb) && (Sum_msb != A_msb), using latched operands.
REQ-022 Start_In and input changes outside an accept edge SHALL be ignored; the result depends only on the values latched at accept.
REQ-023 Sum_Out/Carry_Out/Overflow_Out SHALL hold between completions, including through IDLE.

Reset
REQ-024 With Reset_n low at a rising edge, state->IDLE, index->0, and the carry, operand, working and output registers ->0; Done_Out->0.
REQ-025 Reset in ADD or DONE SHALL abort the operation; no Done_Out pulse and no partial result reach the outputs.
REQ-026 Reset has priority over a simultaneous Start_In.

Structure
REQ-027 Package multi_byte_adder_pkg SHALL hold BYTE_WIDTH=8 and the FSM state enum typedef.
REQ-028 One sub-module, byte_cla_adder: combinational 8-bit carry-lookahead adder with ports Data_A_In, Data_B_In, Carry_In, Sum_Out, Carry_Out; exactly one instance.
REQ-029 Byte selection SHALL use indexed part-selects; no per-byte adder replication.

Verification (NUM_BYTES=4)
REQ-030 A=0x00000001, B=0x00000001, Cin=0 -> Sum 0x00000002, Cout 0, Ovf 0; Done_Out exactly 5 cycles after accept edge.
REQ-031 A=0xFFFFFFFF, B=0x00000000, Cin=1 -> Sum 0x00000000, Cout 1, Ovf 0 (carry crosses all byte boundaries).
REQ-032 A=0x7FFFFFFF, B=0x00000001, Cin=0 -> Sum 0x80000000, Cout 0, Ovf 1; then A=0x80000000, B=0x80000000 -> Sum 0, Cout 1, Ovf 1.
REQ-033 Start_In held high, operands changed every cycle -> results match values latched at each accept; accepts spaced exactly 6 edges; Ready_Out 0 in ADD/DONE.
REQ-034 Reset_n low for 1 cycle during ADD byte 2 -> no Done_Out, outputs 0, Ready_Out 1 after release; next add 0x12345678+0x11111111 -> Sum 0x23456789.
REQ-035 Random self-checking: 1000 operations against a reference model, Sum/Cout/Ovf compared on every Done_Out.
